// File: rtl/simd_signed_adder.sv
// Two-stage lane-configurable signed adder (1x, 2x or 4x lanes) with valid/ready handshake.
// Build option: define SIMD_SIGNED_ADDER_SAT_EN to clamp overflowing lanes instead of wrapping.
module simd_signed_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       ovf
);
    localparam int Q = WIDTH / 4;
    localparam logic [1:0] MODE_ONE  = 2'd0;
    localparam logic [1:0] MODE_TWO  = 2'd1;
    localparam logic [1:0] MODE_FOUR = 2'd2;

    logic             adv1, adv2;
    logic [1:0]       mode_n;
    logic             carry;
    logic [Q:0]       q_sum;
    logic [WIDTH-1:0] sum_c;
    logic [3:0]       sa_c, sb_c;

    logic             s1_valid;
    logic [1:0]       s1_mode;
    logic [WIDTH-1:0] s1_sum;
    logic [3:0]       s1_sa, s1_sb;

    logic [3:0]       qo;
    logic [3:0]       ovf_c;
    logic [WIDTH-1:0] res_c;

    assign adv2     = !out_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1 && !reset;

    // Quarter-width adders chained; the chain is cut at every active lane boundary.
    always_comb begin
        mode_n = (mode == 2'd3) ? MODE_ONE : mode;
        carry  = 1'b0;
        q_sum  = '0;
        sum_c  = '0;
        sa_c   = '0;
        sb_c   = '0;
        for (int i = 0; i < 4; i++) begin
            if (mode_n == MODE_FOUR || (i == 2 && mode_n == MODE_TWO))
                carry = 1'b0;
            q_sum = {1'b0, a[i*Q +: Q]} + {1'b0, b[i*Q +: Q]} + {{Q{1'b0}}, carry};
            sum_c[i*Q +: Q] = q_sum[Q-1:0];
            carry   = q_sum[Q];
            sa_c[i] = a[i*Q + Q - 1];
            sb_c[i] = b[i*Q + Q - 1];
        end
    end

    // Overflow computed per quarter; only quarters that are a lane's top are reported.
    always_comb begin
        for (int i = 0; i < 4; i++)
            qo[i] = (s1_sa[i] == s1_sb[i]) && (s1_sum[i*Q + Q - 1] != s1_sa[i]);
        case (s1_mode)
            MODE_TWO:  ovf_c = {2'b00, qo[3], qo[1]};
            MODE_FOUR: ovf_c = qo;
            default:   ovf_c = {3'b000, qo[3]};
        endcase
        res_c = s1_sum;
`ifdef SIMD_SIGNED_ADDER_SAT_EN
        for (int i = 0; i < 4; i++) begin
            int t;
            case (s1_mode)
                MODE_TWO:  t = (i < 2) ? 1 : 3;
                MODE_FOUR: t = i;
                default:   t = 3;
            endcase
            if (qo[t]) begin
                if (i == t)
                    res_c[i*Q +: Q] = s1_sa[t] ? {1'b1, {(Q-1){1'b0}}} : {1'b0, {(Q-1){1'b1}}};
                else
                    res_c[i*Q +: Q] = s1_sa[t] ? {Q{1'b0}} : {Q{1'b1}};
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_mode   <= MODE_ONE;
            s1_sum    <= '0;
            s1_sa     <= '0;
            s1_sb     <= '0;
            out_valid <= 1'b0;
            out       <= '0;
            ovf       <= '0;
        end else begin
            if (adv1) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_mode <= mode_n;
                    s1_sum  <= sum_c;
                    s1_sa   <= sa_c;
                    s1_sb   <= sb_c;
                end
            end
            if (adv2) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out <= res_c;
                    ovf <= ovf_c;
                end
            end
        end
    end
endmodule

// File: tb/tb_simd_signed_adder.sv
// Directed-vector bench for simd_signed_adder: lane arithmetic, latency, backpressure, reset flush.
// Expected results follow SIMD_SIGNED_ADDER_SAT_EN when it is defined for the build.
module tb_simd_signed_adder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  mode = 2'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out;
    logic [3:0]  ovf;

    simd_signed_adder #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] out_w;
        logic [31:0] out_s;
        logic [3:0]  ovf;
    } vec_t;

    typedef struct {
        logic [31:0] out;
        logic [3:0]  ovf;
        int          acc;
    } exp_t;

    vec_t vec[12];
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   cur_idx = 0;
    int   rx_cnt = 0;
    bit   check_lat = 1'b1;
    bit   prev_stall = 1'b0;
    logic [31:0] held_out;
    logic [3:0]  held_ovf;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: pop on drain, push on accept, watch stall stability.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                rx_cnt = rx_cnt + 1;
                checks = checks + 1;
                if (exp_q.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL unexpected_beat out=%h ovf=%b (no beat outstanding)", out, ovf);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (out !== e.out) begin
                        errors = errors + 1;
                        $display("FAIL result_out got=%h want=%h", out, e.out);
                    end
                    checks = checks + 1;
                    if (ovf !== e.ovf) begin
                        errors = errors + 1;
                        $display("FAIL result_ovf got=%b want=%b", ovf, e.ovf);
                    end
                    if (check_lat) begin
                        checks = checks + 1;
                        if (cyc - e.acc != 2) begin
                            errors = errors + 1;
                            $display("FAIL latency got=%0d want=2", cyc - e.acc);
                        end
                    end
                end
            end
            if (out_valid && !out_ready && prev_stall) begin
                checks = checks + 1;
                if (out !== held_out || ovf !== held_ovf) begin
                    errors = errors + 1;
                    $display("FAIL stall_stable got=%h/%b want=%h/%b", out, ovf, held_out, held_ovf);
                end
            end
            prev_stall = out_valid && !out_ready;
            held_out   = out;
            held_ovf   = ovf;
            if (in_valid && in_ready) begin
                exp_t e;
`ifdef SIMD_SIGNED_ADDER_SAT_EN
                e.out = vec[cur_idx].out_s;
`else
                e.out = vec[cur_idx].out_w;
`endif
                e.ovf = vec[cur_idx].ovf;
                e.acc = cyc;
                exp_q.push_back(e);
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic set_vec(input int idx);
        cur_idx = idx;
        mode    = vec[idx].mode;
        a       = vec[idx].a;
        b       = vec[idx].b;
    endtask

    task automatic drive_beat(input int idx);
        bit acc = 1'b0;
        int n = 0;
        set_vec(idx);
        in_valid = 1'b1;
        while (!acc && n < 20) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout vector=%0d in_ready stayed 0", idx);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout outstanding=%0d want=0", exp_q.size());
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%b want=%b", name, got, want);
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int bp_list[4];
        int k;
        int acc_cnt;
        int rx_start;
        int n;

        vec[0]  = '{2'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h7FFFFFFF, 4'b0001};
        vec[1]  = '{2'd3, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h7FFFFFFF, 4'b0001};
        vec[2]  = '{2'd2, 32'h7F80FF01, 32'h0180017F, 32'h80000080, 32'h7F80007F, 4'b1101};
        vec[3]  = '{2'd1, 32'h00018000, 32'h0001FFFF, 32'h00027FFF, 32'h00028000, 4'b0001};
        vec[4]  = '{2'd0, 32'h00000005, 32'hFFFFFFFD, 32'h00000002, 32'h00000002, 4'b0000};
        vec[5]  = '{2'd0, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 4'b0001};
        vec[6]  = '{2'd2, 32'h01020304, 32'h10203040, 32'h11223344, 32'h11223344, 4'b0000};
        vec[7]  = '{2'd1, 32'h7FFF0001, 32'h00010001, 32'h80000002, 32'h7FFF0002, 4'b0010};
        vec[8]  = '{2'd0, 32'h0000FFFF, 32'h00000001, 32'h00010000, 32'h00010000, 4'b0000};
        vec[9]  = '{2'd2, 32'h000000FF, 32'h00000001, 32'h00000000, 32'h00000000, 4'b0000};
        vec[10] = '{2'd1, 32'h0000FFFF, 32'h00000001, 32'h00000000, 32'h00000000, 4'b0000};
        vec[11] = '{2'd2, 32'h80808080, 32'h80808080, 32'h00000000, 32'h80808080, 4'b1111};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_bit("reset_in_ready", in_ready, 1'b0);
        check_bit("reset_out_valid", out_valid, 1'b0);
        check_word("reset_out", out, 32'h0);
        check_word("reset_ovf", {28'h0, ovf}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_bit("post_reset_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Isolated beats, one per table entry
        for (int i = 0; i < 12; i++) begin
            drive_beat(i);
            drain();
        end

        // Back-to-back with modes alternating 0/1/2
        for (int r = 0; r < 2; r++) begin
            drive_beat(4);
            drive_beat(7);
            drive_beat(2);
            drive_beat(5);
            drive_beat(3);
            drive_beat(11);
        end
        drain();

        // Backpressure: only two beats fit while out_ready is low
        check_lat = 1'b0;
        bp_list  = '{2, 3, 6, 7};
        rx_start = rx_cnt;
        out_ready = 1'b0;
        k = 0;
        acc_cnt = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            set_vec(bp_list[k < 4 ? k : 3]);
            @(negedge clk);
            if (in_ready) begin
                acc_cnt++;
                k++;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (acc_cnt != 2) begin
            errors++;
            $display("FAIL bp_accepted got=%0d want=2", acc_cnt);
        end
        @(negedge clk);
        check_bit("bp_in_ready_low", in_ready, 1'b0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        n = 0;
        while (k < 4 && n < 20) begin
            set_vec(bp_list[k]);
            @(negedge clk);
            if (in_ready) k++;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        drain();
        checks++;
        if (rx_cnt - rx_start != 4) begin
            errors++;
            $display("FAIL bp_received got=%0d want=4", rx_cnt - rx_start);
        end
        check_lat = 1'b1;

        // Reset with two beats in flight
        drive_beat(0);
        drive_beat(2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_bit("flush_out_valid", out_valid, 1'b0);
        check_word("flush_out", out, 32'h0);
        check_word("flush_ovf", {28'h0, ovf}, 32'h0);
        check_bit("flush_in_ready", in_ready, 1'b0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        rx_start = rx_cnt;
        drive_beat(6);
        drain();
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (rx_cnt - rx_start != 1) begin
            errors++;
            $display("FAIL flush_received got=%0d want=1", rx_cnt - rx_start);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
